// File: rtl/count_sched.sv
// Round-robin scheduler that time-shares one external loadable up-counter among NREQ
// requesters, running each owner's interval from its start value up to all-ones.
module count_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_start,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt_data,
  output logic                  cnt_load,
  output logic                  cnt_enable,
  input  logic [WIDTH-1:0]      cnt_count
);

  // state | meaning
  // IDLE  | no owner; arbitrate among pending requests
  // LOAD  | load owner's start value into the counter
  // RUN   | counter enabled until it reaches terminal count
  // DONE  | one-cycle done pulse to the owner
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] TC = '1;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   owner_nxt;
  logic [PW-1:0]   rr_cand;
  logic [PW-1:0]   rr_pick;
  logic            rr_found;
  logic [WIDTH-1:0] start_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      start_arr[i] = req_start[i*WIDTH +: WIDTH];
    end
  end

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    rr_pick  = ptr_q;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  assign owner_nxt = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    gnt        = '0;
    done       = '0;
    busy       = (state_q != ST_IDLE);
    cnt_data   = '0;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    if (state_q != ST_IDLE) gnt[owner_q] = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          owner_d = rr_pick;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_load = 1'b1;
        cnt_data = start_arr[owner_q];
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        // Owner withdrawing its request abandons the interval without a done pulse.
        if (!req[owner_q]) begin
          ptr_d   = owner_nxt;
          state_d = ST_IDLE;
        end else if (cnt_count == TC) begin
          state_d = ST_DONE;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      ST_DONE: begin
        done[owner_q] = 1'b1;
        ptr_d         = owner_nxt;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: external counter model, interval-level reference model checked
// every cycle, table-driven single-request vectors and hand-written corner sequences.
module tb_count_sched;
  localparam int NREQ = 4;
  localparam int W    = 5;
  localparam int TCV  = 31;

  logic            clk = 1'b0;
  logic            rst_ = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] req_start = '0;
  logic [NREQ-1:0] gnt, done;
  logic            busy, cnt_load, cnt_enable;
  logic [W-1:0]    cnt_data;
  logic [W-1:0]    cnt_count = '0;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  count_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .rst_(rst_), .req(req), .req_start(req_start),
    .gnt(gnt), .done(done), .busy(busy),
    .cnt_data(cnt_data), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .cnt_count(cnt_count)
  );

  always #5 clk = ~clk;

  // The shared counter this block controls.
  always @(posedge clk) begin
    if (cnt_load) cnt_count <= cnt_data;
    else if (cnt_enable) cnt_count <= cnt_count + 5'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int start_of(input int i);
    return int'(req_start[i*W +: W]);
  endfunction

  // Reference model: an interval is a sequence of cycles t = 0 (load), 1..L (run, L = TC-S+1),
  // L+1 (done pulse), where S is the start value captured on the load cycle.
  int m_active = 0, m_owner = 0, m_t = 0, m_s = 0, m_ptr = 0;

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return ptr;
  endfunction

  always @(posedge clk) begin
    if (!rst_) begin
      m_active = 0; m_ptr = 0; m_owner = 0;
    end else if (m_active == 0) begin
      if (|req) begin m_owner = rr_pick(m_ptr, req); m_active = 1; m_t = 0; end
    end else if (m_t == 0) begin
      m_s = start_of(m_owner); m_t = 1;
    end else if (m_t <= TCV + 1 - m_s) begin
      if (!req[m_owner]) begin m_active = 0; m_ptr = (m_owner + 1) % NREQ; end
      else m_t++;
    end else begin
      m_active = 0; m_ptr = (m_owner + 1) % NREQ;
    end
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] e_gnt, e_done;
    logic e_busy, e_load, e_en;
    logic [W-1:0] e_data;
    int lim;
    e_gnt = '0; e_done = '0; e_busy = 1'b0; e_load = 1'b0; e_en = 1'b0; e_data = '0;
    if (m_active != 0) begin
      e_gnt[m_owner] = 1'b1;
      e_busy = 1'b1;
      lim = TCV + 1 - m_s;
      if (m_t == 0) begin
        e_load = 1'b1;
        e_data = W'(start_of(m_owner));
      end else if (m_t <= lim) begin
        e_en = req[m_owner] && (m_t < lim);
      end else begin
        e_done[m_owner] = 1'b1;
      end
    end
    if (model_on)
      chk("model_outputs", {16'd0, gnt, done, busy, cnt_data, cnt_load, cnt_enable},
          {16'd0, e_gnt, e_done, e_busy, e_data, e_load, e_en});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_ = 1'b0;
    repeat (2) tick();
    rst_ = 1'b1;
  endtask

  task automatic set_start(input int i, input int v);
    req_start[i*W +: W] = W'(v);
  endtask

  typedef struct {
    int idx;
    int start;
    int exp_done;
    int exp_en;
  } vec_t;

  vec_t vecs [5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int load_c, load_d, en_n, done_c, gcnt, bound;
    int order [5];
    int exp_order [5];
    bit prev_done;

    // Reset with all requests asserted.
    req = '1;
    rst_ = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {16'd0, gnt, done, busy, cnt_data, cnt_load, cnt_enable}, 32'd0);
    #1;
    req = '0;
    rst_ = 1'b1;
    model_on = 1'b1;
    repeat (2) tick();

    // Single-request vectors: done cycle = TC-S+3, enable cycles = TC-S.
    vecs[0] = '{idx: 0, start: 28, exp_done: 6,  exp_en: 3};
    vecs[1] = '{idx: 1, start: 31, exp_done: 3,  exp_en: 0};
    vecs[2] = '{idx: 1, start: 0,  exp_done: 34, exp_en: 31};
    vecs[3] = '{idx: 3, start: 17, exp_done: 17, exp_en: 14};
    vecs[4] = '{idx: 2, start: 30, exp_done: 4,  exp_en: 1};
    foreach (vecs[v]) begin
      load_c = -1; load_d = -1; en_n = 0; done_c = -1;
      set_start(vecs[v].idx, vecs[v].start);
      req = '0;
      req[vecs[v].idx] = 1'b1;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (cnt_load) begin
          load_c = c;
          load_d = int'(cnt_data);
          chk("vec_gnt_at_load", {28'd0, gnt}, 32'd1 << vecs[v].idx);
        end
        if (cnt_enable) en_n++;
        if (done[vecs[v].idx]) begin done_c = c; break; end
      end
      chk("vec_load_cycle", load_c, 1);
      chk("vec_load_data", load_d, vecs[v].start);
      chk("vec_enable_cycles", en_n, vecs[v].exp_en);
      chk("vec_done_cycle", done_c, vecs[v].exp_done);
      tick();
      req = '0;
      tick();
    end

    // Fairness with all four requesting and start 30.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_start(i, 30);
    req = '1;
    gcnt = 0; prev_done = 1'b0;
    exp_order = '{0, 1, 2, 3, 0};
    for (bound = 0; bound < 200 && gcnt < 5; bound++) begin
      @(negedge clk);
      if (prev_done) chk("fair_idle_gap", {31'd0, busy}, 32'd0);
      prev_done = |done;
      if (cnt_load) begin
        order[gcnt] = -1;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) order[gcnt] = i;
        gcnt++;
      end
    end
    chk("fair_grant_count", gcnt, 5);
    for (int g = 0; g < 5; g++) chk("fair_grant_order", (g < gcnt) ? order[g] : -1, exp_order[g]);
    tick();
    req = '0;
    repeat (3) tick();

    // Abort: requester 2 drops in its third run cycle; next grant goes to 3 ahead of 0.
    do_reset();
    set_start(2, 20);
    req = 4'b0100;
    repeat (4) tick();
    req = 4'b1001;
    @(negedge clk);
    chk("abort_enable_same", {31'd0, cnt_enable}, 32'd0);
    tick();
    @(negedge clk);
    chk("abort_enable_next", {31'd0, cnt_enable}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_done", {28'd0, done}, 32'd0);
    tick();
    @(negedge clk);
    chk("abort_next_gnt", {28'd0, gnt}, 32'h8);
    chk("abort_next_load", {31'd0, cnt_load}, 32'd1);
    tick();
    req = '0;
    repeat (3) tick();

    // Reset in the middle of a run.
    set_start(0, 28);
    req = 4'b0001;
    repeat (3) tick();
    @(negedge clk);
    chk("midrst_count", {27'd0, cnt_count}, 32'd29);
    #1;
    rst_ = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_gnt", {28'd0, gnt}, 32'd0);
    chk("midrst_enable", {31'd0, cnt_enable}, 32'd0);
    chk("midrst_done", {28'd0, done}, 32'd0);
    #1;
    rst_ = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_reload", {31'd0, cnt_load}, 32'd1);
    chk("midrst_regnt", {28'd0, gnt}, 32'd1);
    done_c = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done[0]) begin done_c = c; break; end
    end
    chk("midrst_done_after", done_c, 4);
    tick();
    req = '0;
    repeat (2) tick();

    // Randomised traffic against the reference model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            set_start(i, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                                     : int'($urandom_range(22, 31)));
          end
        end else begin
          if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
          else if ($urandom_range(0, 19) == 0) set_start(i, int'($urandom_range(0, 31)));
        end
      end
      rst_ = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_ = 1'b1;
    req = '0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
